// File: rtl/acc_multi_if.sv
// Bus bundle for acc_multi: serial frame inputs, channel selects and read-back outputs.
// The master side drives frames and selects; the slave side is the accumulator block.
interface acc_multi_if #(
    parameter int ACC_W    = 128,
    parameter int CHANNELS = 4
);
    localparam int CH_W = $clog2(CHANNELS);

    logic                rx;
    logic                add;
    logic                sub;
    logic                clear;
    logic [CH_W-1:0]     ch_sel;
    logic [CH_W-1:0]     rd_sel;
    logic [ACC_W-1:0]    acc_out;
    logic [CHANNELS-1:0] ovf;
    logic                long_frame;
    logic                busy;
    logic                done;
    logic [CH_W-1:0]     done_ch;

    modport master (
        output rx, add, sub, clear, ch_sel, rd_sel,
        input  acc_out, ovf, long_frame, busy, done, done_ch
    );

    modport slave (
        input  rx, add, sub, clear, ch_sel, rd_sel,
        output acc_out, ovf, long_frame, busy, done, done_ch
    );
endinterface

// File: rtl/acc_multi.sv
// Multi-channel serial accumulator: MSB-first frames gated by add are shifted in,
// then added to or subtracted from one of CHANNELS accumulators with sticky overflow.
module acc_multi #(
    parameter int SHIFT_W  = 33,
    parameter int ACC_W    = 128,
    parameter int CHANNELS = 4,
    parameter int SAT      = 0
) (
    input  logic       clk,
    input  logic       rst,
    acc_multi_if.slave bus
);
    localparam int CH_W  = $clog2(CHANNELS);
    localparam int CNT_W = $clog2(SHIFT_W + 1);
    localparam int PAD_W = ACC_W + 1 - SHIFT_W;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_reg, state_next;
    logic [SHIFT_W-1:0]  shift_reg, shift_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [CH_W-1:0]     cur_ch_reg, cur_ch_next;
    logic                cur_sub_reg, cur_sub_next;
    logic                long_reg, long_next;
    logic                done_reg, done_next;
    logic [CH_W-1:0]     done_ch_reg, done_ch_next;
    logic [ACC_W-1:0]    acc_reg  [CHANNELS];
    logic [ACC_W-1:0]    acc_next [CHANNELS];
    logic [CHANNELS-1:0] ovf_reg, ovf_next;

    logic                commit;
    logic                clr;
    logic [ACC_W-1:0]    cur_acc;
    logic [ACC_W:0]      sum;
    logic                ovf_hit;
    logic [ACC_W-1:0]    commit_val;

    // One extra bit of width exposes carry on add and borrow on subtract alike.
    assign cur_acc = acc_reg[cur_ch_reg];
    assign sum     = cur_sub_reg ? ({1'b0, cur_acc} - {{PAD_W{1'b0}}, shift_reg})
                                 : ({1'b0, cur_acc} + {{PAD_W{1'b0}}, shift_reg});
    assign ovf_hit = sum[ACC_W];

    generate
        if (SAT != 0) begin : g_sat
            assign commit_val = ovf_hit ? (cur_sub_reg ? '0 : '1) : sum[ACC_W-1:0];
        end else begin : g_wrap
            assign commit_val = sum[ACC_W-1:0];
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        cnt_next     = cnt_reg;
        cur_ch_next  = cur_ch_reg;
        cur_sub_next = cur_sub_reg;
        long_next    = long_reg;
        done_next    = 1'b0;
        done_ch_next = done_ch_reg;
        commit       = 1'b0;
        clr          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.add && !bus.clear) begin
                    shift_next   = {{(SHIFT_W-1){1'b0}}, bus.rx};
                    cnt_next     = CNT_W'(1);
                    cur_ch_next  = bus.ch_sel;
                    cur_sub_next = bus.sub;
                    state_next   = SHIFT;
                end else if (bus.clear && !bus.add) begin
                    clr = 1'b1;
                end
            end
            SHIFT: begin
                if (bus.add) begin
                    shift_next = {shift_reg[SHIFT_W-2:0], bus.rx};
                    // Once full, every further bit pushes out the oldest one.
                    if (cnt_reg == CNT_W'(SHIFT_W)) begin
                        long_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end else begin
                    commit       = 1'b1;
                    shift_next   = '0;
                    done_next    = 1'b1;
                    done_ch_next = cur_ch_reg;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic hit_commit;
            logic hit_clr;
            assign hit_commit   = commit && (cur_ch_reg == CH_W'(gi));
            assign hit_clr      = clr && (bus.ch_sel == CH_W'(gi));
            assign acc_next[gi] = hit_commit ? commit_val :
                                  hit_clr    ? '0         : acc_reg[gi];
            assign ovf_next[gi] = hit_commit ? (ovf_reg[gi] | ovf_hit) :
                                  hit_clr    ? 1'b0                    : ovf_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            cnt_reg     <= '0;
            cur_ch_reg  <= '0;
            cur_sub_reg <= 1'b0;
            long_reg    <= 1'b0;
            done_reg    <= 1'b0;
            done_ch_reg <= '0;
            ovf_reg     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc_reg[i] <= '0;
            end
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            cnt_reg     <= cnt_next;
            cur_ch_reg  <= cur_ch_next;
            cur_sub_reg <= cur_sub_next;
            long_reg    <= long_next;
            done_reg    <= done_next;
            done_ch_reg <= done_ch_next;
            ovf_reg     <= ovf_next;
            for (int i = 0; i < CHANNELS; i++) begin
                acc_reg[i] <= acc_next[i];
            end
        end
    end

    assign bus.acc_out    = acc_reg[bus.rd_sel];
    assign bus.ovf        = ovf_reg;
    assign bus.long_frame = long_reg;
    assign bus.busy       = (state_reg == SHIFT);
    assign bus.done       = done_reg;
    assign bus.done_ch    = done_ch_reg;
endmodule

// File: tb/tb_acc_multi.sv
// Drives one shared stimulus stream into three acc_multi configurations (wide wrap,
// narrow wrap, narrow saturate) and compares each against an arithmetic model.
module tb_acc_multi;
    logic       clk = 1'b0;
    logic       rst;
    logic       rx, add, sub, clear;
    logic [1:0] ch_sel, rd_sel;

    int total = 0;
    int bad   = 0;
    int done_cnt [3] = '{0, 0, 0};
    int exp_done    = 0;
    int exp_done_ch = 0;

    logic [127:0] mdl_acc  [3][4];
    logic [3:0]   mdl_ovf  [3];
    logic         mdl_long [3];

    acc_multi_if #(.ACC_W(128), .CHANNELS(4)) bus_a ();
    acc_multi_if #(.ACC_W(8),   .CHANNELS(4)) bus_b ();
    acc_multi_if #(.ACC_W(8),   .CHANNELS(4)) bus_c ();

    assign bus_a.rx = rx;   assign bus_a.add = add;   assign bus_a.sub = sub;
    assign bus_a.clear = clear; assign bus_a.ch_sel = ch_sel; assign bus_a.rd_sel = rd_sel;
    assign bus_b.rx = rx;   assign bus_b.add = add;   assign bus_b.sub = sub;
    assign bus_b.clear = clear; assign bus_b.ch_sel = ch_sel; assign bus_b.rd_sel = rd_sel;
    assign bus_c.rx = rx;   assign bus_c.add = add;   assign bus_c.sub = sub;
    assign bus_c.clear = clear; assign bus_c.ch_sel = ch_sel; assign bus_c.rd_sel = rd_sel;

    acc_multi #(.SHIFT_W(33), .ACC_W(128), .CHANNELS(4), .SAT(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    acc_multi #(.SHIFT_W(8),  .ACC_W(8),   .CHANNELS(4), .SAT(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    acc_multi #(.SHIFT_W(8),  .ACC_W(8),   .CHANNELS(4), .SAT(1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (bus_a.done) done_cnt[0] <= done_cnt[0] + 1;
        if (bus_b.done) done_cnt[1] <= done_cnt[1] + 1;
        if (bus_c.done) done_cnt[2] <= done_cnt[2] + 1;
    end

    function automatic int accw(input int d); return (d == 0) ? 128 : 8; endfunction
    function automatic int shw(input int d);  return (d == 0) ? 33 : 8;  endfunction
    function automatic bit sat(input int d);  return (d == 2);           endfunction

    function automatic logic [127:0] get_acc(input int d);
        case (d)
            0:       return bus_a.acc_out;
            1:       return {120'd0, bus_b.acc_out};
            default: return {120'd0, bus_c.acc_out};
        endcase
    endfunction
    function automatic logic [3:0] get_ovf(input int d);
        case (d) 0: return bus_a.ovf; 1: return bus_b.ovf; default: return bus_c.ovf; endcase
    endfunction
    function automatic logic get_long(input int d);
        case (d) 0: return bus_a.long_frame; 1: return bus_b.long_frame; default: return bus_c.long_frame; endcase
    endfunction
    function automatic logic get_busy(input int d);
        case (d) 0: return bus_a.busy; 1: return bus_b.busy; default: return bus_c.busy; endcase
    endfunction
    function automatic logic get_done(input int d);
        case (d) 0: return bus_a.done; 1: return bus_b.done; default: return bus_c.done; endcase
    endfunction
    function automatic logic [1:0] get_done_ch(input int d);
        case (d) 0: return bus_a.done_ch; 1: return bus_b.done_ch; default: return bus_c.done_ch; endcase
    endfunction

    task automatic chk(input string tag, input int d, input logic [130:0] obs, input logic [130:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 4; c++) mdl_acc[d][c] = '0;
            mdl_ovf[d]  = '0;
            mdl_long[d] = 1'b0;
        end
        exp_done_ch = 0;
    endtask

    // Frame value is the last shw(d) bits received; result judged against 2^accw(d).
    task automatic model_commit(input int ch, input bit s, input int n, input logic [63:0] bits);
        logic [130:0] a, v, lim, r;
        for (int d = 0; d < 3; d++) begin
            lim = 131'd1 << accw(d);
            v   = {67'd0, bits} & ((131'd1 << shw(d)) - 1);
            a   = {3'd0, mdl_acc[d][ch]};
            if (n > shw(d)) mdl_long[d] = 1'b1;
            if (!s) begin
                r = a + v;
                if (r >= lim) begin
                    mdl_ovf[d][ch] = 1'b1;
                    r = sat(d) ? lim - 1 : r - lim;
                end
            end else begin
                if (v > a) begin
                    mdl_ovf[d][ch] = 1'b1;
                    r = sat(d) ? 131'd0 : a + lim - v;
                end else begin
                    r = a - v;
                end
            end
            mdl_acc[d][ch] = r[127:0];
        end
        exp_done++;
        exp_done_ch = ch;
    endtask

    task automatic check_all();
        for (int c = 0; c < 4; c++) begin
            rd_sel = 2'(c);
            #1;
            for (int d = 0; d < 3; d++) chk($sformatf("acc[%0d]", c), d, get_acc(d), mdl_acc[d][c]);
        end
        for (int d = 0; d < 3; d++) begin
            chk("ovf", d, get_ovf(d), mdl_ovf[d]);
            chk("long_frame", d, get_long(d), mdl_long[d]);
            chk("busy_idle", d, get_busy(d), 0);
        end
    endtask

    task automatic chk_acc(input int d, input int c, input logic [127:0] exp);
        rd_sel = 2'(c);
        #1;
        chk($sformatf("fixed_acc[%0d]", c), d, get_acc(d), exp);
    endtask

    task automatic frame(input int ch, input bit s, input int n, input logic [63:0] bits, input bit noise);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            add = 1'b1;
            rx  = bits[n-1-i];
            if (i == 0) begin
                sub = s; ch_sel = 2'(ch); clear = 1'b0;
            end else if (noise) begin
                sub = 1'($urandom); ch_sel = 2'($urandom); clear = 1'($urandom);
            end
            if (i == 0) begin
                @(posedge clk); #1;
                for (int d = 0; d < 3; d++) begin
                    chk("done_low_in_frame", d, get_done(d), 0);
                    chk("busy_in_frame", d, get_busy(d), 1);
                end
            end
        end
        @(negedge clk);
        add = 1'b0; clear = 1'b0; rx = 1'b0;
        @(posedge clk); #1;
        model_commit(ch, s, n, bits);
        for (int d = 0; d < 3; d++) begin
            chk("done_pulse", d, get_done(d), 1);
            chk("done_ch", d, get_done_ch(d), exp_done_ch);
        end
        check_all();
        $display("frame ch=%0d sub=%0d n=%0d bits=%0h acc_a=%0h", ch, s, n, bits, mdl_acc[0][ch]);
    endtask

    task automatic do_clear(input int ch, input bit with_add);
        @(negedge clk);
        clear = 1'b1; ch_sel = 2'(ch); add = with_add; rx = 1'($urandom);
        @(negedge clk);
        clear = 1'b0; add = 1'b0;
        if (!with_add) begin
            for (int d = 0; d < 3; d++) begin
                mdl_acc[d][ch] = '0;
                mdl_ovf[d][ch] = 1'b0;
            end
        end
        check_all();
        $display("clear ch=%0d with_add=%0d", ch, with_add);
    endtask

    initial begin
        logic [63:0] bits;
        int n, ch;
        rx = 0; add = 0; sub = 0; clear = 0; ch_sel = 0; rd_sel = 0;
        rst = 1'b1;
        model_reset();
        #3;
        check_all();
        for (int d = 0; d < 3; d++) begin
            chk("reset_done", d, get_done(d), 0);
            chk("reset_done_ch", d, get_done_ch(d), 0);
        end
        $display("reset check at t=%0t", $time);
        @(negedge clk);
        rst = 1'b0;

        frame(2, 0, 8, 64'hA7, 0);
        chk_acc(0, 2, 128'hA7);

        frame(1, 0, 3, 64'h5, 0);
        frame(1, 1, 2, 64'h3, 0);
        chk_acc(0, 1, 128'h2);

        frame(0, 0, 40, 64'h0000_00FE_0000_0000, 0);
        chk_acc(0, 0, 128'h0);
        frame(0, 0, 40, 64'h1, 0);
        chk_acc(0, 0, 128'h1);

        do_clear(0, 0);
        frame(0, 0, 8, 64'hF0, 0);
        frame(0, 0, 8, 64'h20, 0);
        chk_acc(1, 0, 128'h10);
        chk_acc(2, 0, 128'hFF);
        do_clear(0, 0);
        frame(0, 1, 1, 64'h1, 0);
        chk_acc(1, 0, 128'hFF);
        chk_acc(2, 0, 128'h00);

        do_clear(2, 0);
        chk_acc(0, 2, 128'h0);
        frame(3, 0, 5, 64'h13, 0);
        do_clear(3, 1);
        chk_acc(0, 3, 128'h13);
        frame(3, 0, 12, 64'hABC, 1);

        // Asynchronous reset between clock edges with nonzero state present.
        @(negedge clk); #1;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        for (int d = 0; d < 3; d++) chk("async_reset_done_ch", d, get_done_ch(d), 0);
        $display("async reset at t=%0t", $time);
        @(negedge clk);
        rst = 1'b0;

        // Partial frame into channel 1 interrupted by reset.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            add = 1'b1; rx = 1'b1; sub = 1'b0; ch_sel = 2'd1;
        end
        @(posedge clk); #3;
        rst = 1'b1; add = 1'b0;
        #2;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all();
        for (int d = 0; d < 3; d++) chk("done_cnt_after_abort", d, done_cnt[d], exp_done);
        $display("reset mid-frame, done count=%0d", exp_done);

        for (int k = 0; k < 40; k++) begin
            ch = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) begin
                do_clear(ch, 1'($urandom_range(0, 1)));
            end else begin
                n    = $urandom_range(1, 40);
                bits = {$urandom, $urandom};
                if (n < 64) bits = bits & ((64'd1 << n) - 1);
                frame(ch, 1'($urandom_range(0, 1)), n, bits, 1'($urandom_range(0, 1)));
            end
        end

        @(negedge clk); #1;
        for (int d = 0; d < 3; d++) chk("done_cnt", d, done_cnt[d], exp_done);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
